// File: rtl/video_rx_pkg.sv
// Shared types, default video timing and the frame-signature step for the capture receiver.
package video_rx_pkg;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} rx_state_t;

  localparam int unsigned DEF_H_BACK   = 23;
  localparam int unsigned DEF_H_ACTIVE = 256;
  localparam int unsigned DEF_V_BACK   = 5;
  localparam int unsigned DEF_V_ACTIVE = 240;
  localparam int unsigned DEF_H_W      = 10;
  localparam int unsigned DEF_V_W      = 10;
  localparam int unsigned SIG_W        = 16;

  // Rotate left by one, then fold in the pixel colour.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] sig,
                                                input logic [2:0]       pix);
    return {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(pix);
  endfunction

endpackage

// File: rtl/video_capture_rx_sync_fall_detect.sv
// Input register for one sync line plus a falling-edge flag on the first low input cycle.
module sync_fall_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall_c
);

  logic q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= 1'b0;
    else       q <= din;
  end

  assign fall_c = q & ~din;

endmodule

// File: rtl/video_capture_rx.sv
// Video sink: recovers pixel coordinates from hsync/vsync, locks to line/frame timing,
// emits the active pixel stream and a per-frame signature.
module video_capture_rx
  import video_rx_pkg::*;
#(
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned H_W      = DEF_H_W,
  parameter int unsigned V_W      = DEF_V_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hsync,
  input  logic                        vsync,
  input  logic [2:0]                  rgb,
  output logic                        pix_valid,
  output logic [$clog2(H_ACTIVE)-1:0] pix_x,
  output logic [$clog2(V_ACTIVE)-1:0] pix_y,
  output logic [2:0]                  pix_rgb,
  output logic                        frame_done,
  output logic [SIG_W-1:0]            frame_sum,
  output logic                        locked,
  output logic [H_W-1:0]              h_total_meas,
  output logic [V_W-1:0]              v_total_meas,
  output logic                        sync_err
);

  localparam int unsigned XW = $clog2(H_ACTIVE);
  localparam int unsigned YW = $clog2(V_ACTIVE);

  logic             hs_fall_c, vs_fall_c;
  logic [2:0]       rgb_q;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [1:0]       hf_cnt;
  logic [SIG_W-1:0] sig;
  rx_state_t        state;

  sync_fall_detect u_hs (.clk(clk), .reset(reset), .din(hsync), .fall_c(hs_fall_c));
  sync_fall_detect u_vs (.clk(clk), .reset(reset), .din(vsync), .fall_c(vs_fall_c));

  logic [H_W-1:0] h_len_c;
  logic [V_W-1:0] lines_c;
  logic           timeout_c, active_c, h_bad_c;

  // Line length ends on this fall; line count includes an hsync fall coincident with vsync.
  assign h_len_c   = h_cnt + 1'b1;
  assign lines_c   = v_cnt + V_W'(hs_fall_c);
  assign timeout_c = (h_cnt == '1);
  assign h_bad_c   = hs_fall_c && (h_len_c != h_total_meas);
  assign active_c  = (32'(h_cnt) >= H_BACK) && (32'(h_cnt) < H_BACK + H_ACTIVE) &&
                     (32'(v_cnt) >= V_BACK) && (32'(v_cnt) < V_BACK + V_ACTIVE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q        <= '0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      hf_cnt       <= '0;
      sig          <= '0;
      state        <= SEARCH;
      pix_valid    <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_rgb      <= '0;
      frame_done   <= 1'b0;
      frame_sum    <= '0;
      locked       <= 1'b0;
      h_total_meas <= '0;
      v_total_meas <= '0;
      sync_err     <= 1'b0;
    end else begin
      rgb_q      <= rgb;
      h_cnt      <= hs_fall_c ? '0 : h_cnt + 1'b1;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= '0;

      if (vs_fall_c)      v_cnt <= '0;
      else if (hs_fall_c) v_cnt <= v_cnt + 1'b1;

      if (state == LOCKED && active_c) begin
        pix_valid <= 1'b1;
        pix_x     <= XW'(32'(h_cnt) - H_BACK);
        pix_y     <= YW'(32'(v_cnt) - V_BACK);
        pix_rgb   <= rgb_q;
        sig       <= sig_step(sig, rgb_q);
      end

      case (state)
        SEARCH: begin
          if (vs_fall_c) begin
            state  <= MEASURE;
            hf_cnt <= '0;
          end
        end
        // First fall aligns h_cnt, second fall latches the line length, later falls verify it.
        MEASURE: begin
          if (timeout_c || (hf_cnt == 2'd2 && h_bad_c)) begin
            state    <= SEARCH;
            sync_err <= 1'b1;
          end else if (vs_fall_c) begin
            v_total_meas <= lines_c;
            if (hf_cnt == 2'd2 && 32'(lines_c) >= V_BACK + V_ACTIVE) begin
              state  <= LOCKED;
              locked <= 1'b1;
              sig    <= '0;
            end else begin
              state    <= SEARCH;
              sync_err <= 1'b1;
            end
          end else if (hs_fall_c) begin
            if (hf_cnt == 2'd1) h_total_meas <= h_len_c;
            if (hf_cnt != 2'd2) hf_cnt <= hf_cnt + 2'd1;
          end
        end
        LOCKED: begin
          if (timeout_c || h_bad_c || (vs_fall_c && lines_c != v_total_meas)) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            sync_err <= 1'b1;
          end else if (vs_fall_c) begin
            frame_done <= 1'b1;
            frame_sum  <= sig;
            sig        <= '0;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_video_capture_rx.sv
// Directed bench for video_capture_rx using a scaled-down raster (24 clk/line, 13 lines/frame).
module tb_video_capture_rx;

  localparam int HB = 4, HA = 16, VB = 2, VA = 8, HWD = 6, VWD = 5;
  localparam int LINE = 24, HS_HIGH = 3, NL = 13, VS_LINES = 3, NPIX = HA * VA;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync;
  logic [2:0]  rgb;
  logic        pix_valid, frame_done, locked, sync_err;
  logic [3:0]  pix_x;
  logic [2:0]  pix_y, pix_rgb;
  logic [15:0] frame_sum;
  logic [5:0]  h_total_meas;
  logic [4:0]  v_total_meas;

  int n_assert = 0, n_fail = 0;
  int pv_cnt, pix_bad, fd_cnt, se_cnt, pv_after_err;
  bit err_seen;

  logic       h1_v, h2_v;
  logic [3:0] h1_x, h2_x;
  logic [2:0] h1_y, h2_y, h1_rgb, h2_rgb;

  video_capture_rx #(.H_BACK(HB), .H_ACTIVE(HA), .V_BACK(VB), .V_ACTIVE(VA),
                     .H_W(HWD), .V_W(VWD)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_sum(frame_sum), .locked(locked),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] pat(input int p, input int x, input int y);
    case (p)
      0:       return 3'((x ^ y) & 7);
      1:       return (x == HA - 1 && y == VA - 1) ? 3'd1 : 3'd0;
      default: return (x == 0 && y == 0) ? 3'd1 : 3'd0;
    endcase
  endfunction

  function automatic logic [15:0] model_sum(input int p);
    logic [15:0] s = 16'h0;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        s = {s[14:0], s[15]} ^ {13'b0, pat(p, x, y)};
    return s;
  endfunction

  // One clock: sample outputs at negedge, compare against the sample driven two cycles ago, then drive.
  // mode 0: no pixels expected, 1: exact pixel stream expected, 2: unchecked.
  task automatic step(input logic hs, input logic vs, input logic [2:0] rv,
                      input logic act, input int x, input int y, input int mode);
    @(negedge clk);
    if (err_seen && pix_valid) pv_after_err++;
    if (sync_err) begin se_cnt++; err_seen = 1'b1; end
    if (frame_done) fd_cnt++;
    if (pix_valid) pv_cnt++;
    if (mode == 1) begin
      if (pix_valid !== h2_v) pix_bad++;
      else if (h2_v && (pix_x !== h2_x || pix_y !== h2_y || pix_rgb !== h2_rgb)) pix_bad++;
    end else if (mode == 0 && pix_valid !== 1'b0) pix_bad++;
    h2_v = h1_v; h2_x = h1_x; h2_y = h1_y; h2_rgb = h1_rgb;
    h1_v = act;  h1_x = 4'(x); h1_y = 3'(y); h1_rgb = rv;
    hsync = hs; vsync = vs; rgb = rv;
  endtask

  task automatic send_frame(input int nl, input int p, input int mode,
                            input int odd_line, input int odd_len, input int abort_line);
    pv_cnt = 0; pix_bad = 0; fd_cnt = 0; se_cnt = 0; pv_after_err = 0; err_seen = 1'b0;
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == odd_line) ? odd_len : LINE;
      for (int c = 0; c < len; c++) begin
        logic act;
        if (l == abort_line && c == 10) return;
        act = (l >= VB) && (l < VB + VA) && (c >= HB) && (c < HB + HA);
        step(c >= len - HS_HIGH, l >= nl - VS_LINES,
             act ? pat(p, c - HB, l - VB) : 3'd5, act, c - HB, l - VB, mode);
      end
    end
  endtask

  task automatic preamble();
    h1_v = 1'b0; h2_v = 1'b0; h1_x = '0; h2_x = '0; h1_y = '0; h2_y = '0; h1_rgb = '0; h2_rgb = '0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd0, 1'b0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix_xy"}, {25'd0, pix_x, pix_y}, 0);
    check({tag, "_pix_rgb"}, 32'(pix_rgb), 0);
    check({tag, "_frame_done"}, 32'(frame_done), 0);
    check({tag, "_frame_sum"}, 32'(frame_sum), 0);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_h_total"}, 32'(h_total_meas), 0);
    check({tag, "_v_total"}, 32'(v_total_meas), 0);
    check({tag, "_sync_err"}, 32'(sync_err), 0);
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; rgb = 3'd0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    preamble();

    // Nominal acquisition and lock
    send_frame(NL, 0, 0, -1, 0, -1);
    check("f0_locked", 32'(locked), 0);
    check("f0_h_total", 32'(h_total_meas), LINE);
    check("f0_no_pix", 32'(pix_bad), 0);
    send_frame(NL, 0, 1, -1, 0, -1);
    check("f1_locked", 32'(locked), 1);
    check("f1_v_total", 32'(v_total_meas), NL);
    check("f1_pix_cnt", 32'(pv_cnt), NPIX);
    check("f1_pix_bad", 32'(pix_bad), 0);
    check("f1_no_done", 32'(fd_cnt), 0);
    check("f1_no_err", 32'(se_cnt), 0);
    send_frame(NL, 1, 1, -1, 0, -1);
    check("f2_done", 32'(fd_cnt), 1);
    check("f2_pix_cnt", 32'(pv_cnt), NPIX);
    check("f2_pix_bad", 32'(pix_bad), 0);
    check("f2_sum_pat0", 32'(frame_sum), 32'(model_sum(0)));

    // Signature corner pixels
    send_frame(NL, 2, 1, -1, 0, -1);
    check("f3_sum_last_px", 32'(frame_sum), 32'h0001);
    check("f3_pix_bad", 32'(pix_bad), 0);
    send_frame(NL, 0, 1, -1, 0, -1);
    check("f4_sum_first_px", 32'(frame_sum), 32'h8000);
    check("f4_done", 32'(fd_cnt), 1);

    // Short line while locked
    send_frame(NL, 0, 2, 5, 20, -1);
    check("short_err_cnt", 32'(se_cnt), 1);
    check("short_locked", 32'(locked), 0);
    check("short_done_prev", 32'(fd_cnt), 1);
    check("short_no_pix_after", 32'(pv_after_err), 0);
    check("short_h_hold", 32'(h_total_meas), LINE);
    send_frame(NL, 0, 0, -1, 0, -1);
    check("remeas_no_done", 32'(fd_cnt), 0);
    check("remeas_locked", 32'(locked), 0);
    check("remeas_no_err", 32'(se_cnt), 0);
    send_frame(NL, 0, 1, -1, 0, -1);
    check("relock_locked", 32'(locked), 1);
    check("relock_no_done", 32'(fd_cnt), 0);
    check("relock_pix_bad", 32'(pix_bad), 0);
    send_frame(NL, 0, 1, -1, 0, -1);
    check("relock_done", 32'(fd_cnt), 1);

    // Line timeout while locked
    send_frame(NL, 0, 2, 5, 73, -1);
    check("timeout_err_cnt", 32'(se_cnt), 1);
    check("timeout_locked", 32'(locked), 0);
    check("timeout_no_pix_after", 32'(pv_after_err), 0);

    // Too few lines while measuring
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    preamble();
    send_frame(7, 0, 0, -1, 0, -1);
    check("fewlines_meas_err", 32'(se_cnt), 0);
    send_frame(NL, 0, 0, -1, 0, -1);
    check("fewlines_err_cnt", 32'(se_cnt), 1);
    check("fewlines_locked", 32'(locked), 0);
    check("fewlines_v_total", 32'(v_total_meas), 7);
    send_frame(NL, 0, 0, -1, 0, -1);
    send_frame(NL, 0, 1, -1, 0, -1);
    check("fewlines_relock", 32'(locked), 1);
    check("fewlines_pix_cnt", 32'(pv_cnt), NPIX);

    // Asynchronous reset mid-line while locked
    send_frame(NL, 0, 1, 4, LINE, 4);
    check("prerst_valid", 32'(pix_valid), 1);
    check("prerst_sum", 32'(frame_sum), 32'(model_sum(0)));
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    preamble();
    send_frame(NL, 0, 0, -1, 0, -1);
    send_frame(NL, 0, 1, -1, 0, -1);
    check("post_rst_locked", 32'(locked), 1);
    send_frame(NL, 0, 1, -1, 0, -1);
    check("post_rst_done", 32'(fd_cnt), 1);
    check("post_rst_sum", 32'(frame_sum), 32'(model_sum(0)));
    check("post_rst_pix_bad", 32'(pix_bad), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
